// File: rtl/regfile_rob_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_rob_if
// Purpose  : Bundles the read, rename, commit and flush signals of the
//            rename-aware register file.
//            master = dispatch/ROB side, slave = register file.
// Signals  : rdEnable/rdAddr -> rdData/rdTag/rdReady/rdValid (1-cycle read)
//            renameEnable/renameIndex/renameTag        (dispatch rename)
//            commitEnable/commitIndex/commitTag/commitData (ROB retire)
//            flush                                     (mispredict recovery)
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_rob_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 3,
    parameter int NREAD = 2
);
    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

    logic                    rdEnable;
    logic [NREAD*RW-1:0]     rdAddr;
    logic [NREAD*XLEN-1:0]   rdData;
    logic [NREAD*TAG_W-1:0]  rdTag;
    logic [NREAD-1:0]        rdReady;
    logic                    rdValid;
    logic                    renameEnable;
    logic [RW-1:0]           renameIndex;
    logic [TAG_W-1:0]        renameTag;
    logic                    commitEnable;
    logic [RW-1:0]           commitIndex;
    logic [TAG_W-1:0]        commitTag;
    logic [XLEN-1:0]         commitData;
    logic                    flush;

    modport master (
        output rdEnable, rdAddr, renameEnable, renameIndex, renameTag,
               commitEnable, commitIndex, commitTag, commitData, flush,
        input  rdData, rdTag, rdReady, rdValid
    );

    modport slave (
        input  rdEnable, rdAddr, renameEnable, renameIndex, renameTag,
               commitEnable, commitIndex, commitTag, commitData, flush,
        output rdData, rdTag, rdReady, rdValid
    );
endinterface
`default_nettype wire

// File: rtl/regfile_rob.sv
`default_nettype none
// ============================================================================
// Module   : regfile_rob
// Purpose  : Architectural register file with per-register busy bit and ROB
//            tag. NREAD registered read ports, one rename and one commit per
//            cycle, flush clears all rename state.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - regfile_rob_if.slave (read/rename/commit/flush)
// Options  : REGFILE_COMMIT_BYPASS_EN - forward a same-cycle matching commit
//            into the read ports (data = commitData, ready = 1).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_rob #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 3,
    parameter int NREAD = 2
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    regfile_rob_if.slave bus
);
    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [XLEN-1:0]  value_q [NREG];
    logic [TAG_W-1:0] tag_q   [NREG];
    logic [NREG-1:0]  busy_q;
    logic             rdValid_q;

    // ------------------------------------------------------------------
    // State update. Entry 0 is never written, so it stays at its reset
    // value. Priority per entry: flush > rename > matching commit, which
    // gives "busy stays set, tag = renameTag" when rename and commit hit
    // the same register in one cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (bus.commitEnable && bus.commitIndex == RW'(i))
                    value_q[i] <= bus.commitData;

                if (bus.flush) begin
                    busy_q[i] <= 1'b0;
                end else if (bus.renameEnable && bus.renameIndex == RW'(i)) begin
                    busy_q[i] <= 1'b1;
                    tag_q[i]  <= bus.renameTag;
                end else if (bus.commitEnable && bus.commitIndex == RW'(i) &&
                             busy_q[i] && tag_q[i] == bus.commitTag) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdValid_q <= 1'b0;
        else        rdValid_q <= bus.rdEnable;
    end

    assign bus.rdValid = rdValid_q;

    // ------------------------------------------------------------------
    // Read ports: look up pre-edge state, register on rdEnable and hold.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [RW-1:0]    w_addr;
        logic [XLEN-1:0]  w_data;
        logic [TAG_W-1:0] w_tag;
        logic             w_ready;
        logic [XLEN-1:0]  data_q;
        logic [TAG_W-1:0] tagout_q;
        logic             ready_q;

        assign w_addr = bus.rdAddr[p*RW +: RW];

        always_comb begin
            w_data  = value_q[w_addr];
            w_tag   = tag_q[w_addr];
            w_ready = !busy_q[w_addr];
`ifdef REGFILE_COMMIT_BYPASS_EN
            if (bus.commitEnable && bus.commitIndex != '0 &&
                w_addr == bus.commitIndex && busy_q[w_addr] &&
                tag_q[w_addr] == bus.commitTag) begin
                w_data  = bus.commitData;
                w_ready = 1'b1;
            end
`endif
            if (w_addr == '0) begin
                w_data  = '0;
                w_tag   = '0;
                w_ready = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q   <= '0;
                tagout_q <= '0;
                ready_q  <= 1'b0;
            end else if (bus.rdEnable) begin
                data_q   <= w_data;
                tagout_q <= w_tag;
                ready_q  <= w_ready;
            end
        end

        assign bus.rdData[p*XLEN +: XLEN]   = data_q;
        assign bus.rdTag[p*TAG_W +: TAG_W]  = tagout_q;
        assign bus.rdReady[p]               = ready_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_regfile_rob.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_rob
// Purpose  : Self-checking bench for regfile_rob: directed scenarios plus
//            randomized traffic against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_rob;
    localparam int XLEN = 32, NREG = 32, TAG_W = 3, NREAD = 2, RW = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_rob_if #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NREAD(NREAD)) bus ();

    regfile_rob #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NREAD(NREAD)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: architectural state and expected held read outputs.
    logic [XLEN-1:0]  m_val  [NREG];
    bit               m_busy [NREG];
    logic [TAG_W-1:0] m_tag  [NREG];
    logic [XLEN-1:0]  e_data [NREAD];
    logic [TAG_W-1:0] e_tag  [NREAD];
    bit               e_rdy  [NREAD];
    bit               e_valid;

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_val[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
        end
        for (int p = 0; p < NREAD; p++) begin
            e_data[p] = '0; e_tag[p] = '0; e_rdy[p] = 0;
        end
        e_valid = 0;
    endtask

    task automatic compare_all(input string where);
        chk({where, ".rdValid"}, 64'(bus.rdValid), 64'(e_valid));
        for (int p = 0; p < NREAD; p++) begin
            chk($sformatf("%s.data%0d", where, p), 64'(bus.rdData[p*XLEN +: XLEN]), 64'(e_data[p]));
            chk($sformatf("%s.tag%0d", where, p), 64'(bus.rdTag[p*TAG_W +: TAG_W]), 64'(e_tag[p]));
            chk($sformatf("%s.rdy%0d", where, p), 64'(bus.rdReady[p]), 64'(e_rdy[p]));
        end
    endtask

    // One clock of traffic: drive, predict from pre-edge model state, clock,
    // update the model, then compare away from the edge.
    task automatic step(input string where, input bit re, input int a0, input int a1,
                        input bit ren, input int ridx, input int rtag,
                        input bit cen, input int cidx, input int ctag,
                        input logic [XLEN-1:0] cdata, input bit fl);
        int a [NREAD];
        a[0] = a0; a[1] = a1;
        bus.rdEnable     = re;
        bus.rdAddr       = {RW'(a1), RW'(a0)};
        bus.renameEnable = ren;
        bus.renameIndex  = RW'(ridx);
        bus.renameTag    = TAG_W'(rtag);
        bus.commitEnable = cen;
        bus.commitIndex  = RW'(cidx);
        bus.commitTag    = TAG_W'(ctag);
        bus.commitData   = cdata;
        bus.flush        = fl;

        e_valid = re;
        if (re) begin
            for (int p = 0; p < NREAD; p++) begin
                if (a[p] == 0) begin
                    e_data[p] = '0; e_tag[p] = '0; e_rdy[p] = 1;
                end else begin
                    e_data[p] = m_val[a[p]];
                    e_tag[p]  = m_tag[a[p]];
                    e_rdy[p]  = !m_busy[a[p]];
`ifdef REGFILE_COMMIT_BYPASS_EN
                    if (cen && cidx == a[p] && m_busy[a[p]] && m_tag[a[p]] == TAG_W'(ctag)) begin
                        e_data[p] = cdata;
                        e_rdy[p]  = 1;
                    end
`endif
                end
            end
        end

        @(posedge clk);
        if (cen && cidx != 0) begin
            m_val[cidx] = cdata;
            if (m_busy[cidx] && m_tag[cidx] == TAG_W'(ctag)) m_busy[cidx] = 0;
        end
        if (ren && ridx != 0 && !fl) begin
            m_busy[ridx] = 1;
            m_tag[ridx]  = TAG_W'(rtag);
        end
        if (fl) for (int i = 0; i < NREG; i++) m_busy[i] = 0;
        #1;
        compare_all(where);
    endtask

    task automatic rd(input string where, input int a0, input int a1);
        step(where, 1, a0, a1, 0, 0, 0, 0, 0, 0, '0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.rdEnable = 0; bus.rdAddr = '0; bus.renameEnable = 0; bus.renameIndex = '0;
        bus.renameTag = '0; bus.commitEnable = 0; bus.commitIndex = '0; bus.commitTag = '0;
        bus.commitData = '0; bus.flush = 0;
        model_reset();
        #12;
        compare_all("reset");
        rst_n = 1'b1;
        #3;

        // Reset then read x5 and x0.
        rd("rd_x5_x0", 5, 0);
        chk("reset_rd.data0", 64'(bus.rdData[31:0]), 64'h0);
        chk("reset_rd.rdy", 64'(bus.rdReady), 64'h3);
        chk("reset_rd.valid", 64'(bus.rdValid), 64'h1);

        // Rename x5 -> tag 3, then commit.
        step("ren_x5", 0, 0, 0, 1, 5, 3, 0, 0, 0, '0, 0);
        chk("hold.valid", 64'(bus.rdValid), 64'h0);
        rd("rd_x5_busy", 5, 5);
        chk("x5_busy.rdy", 64'(bus.rdReady), 64'h0);
        chk("x5_busy.tag", 64'(bus.rdTag[2:0]), 64'h3);
        step("cmt_x5", 0, 0, 0, 0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0);
        rd("rd_x5_cmt", 5, 0);
        chk("x5_cmt.data", 64'(bus.rdData[31:0]), 64'hDEADBEEF);
        chk("x5_cmt.rdy", 64'(bus.rdReady[0]), 64'h1);

        // Stale-tag commit on x7.
        step("ren_x7_t2", 0, 0, 0, 1, 7, 2, 0, 0, 0, '0, 0);
        step("ren_x7_t4", 0, 0, 0, 1, 7, 4, 0, 0, 0, '0, 0);
        step("cmt_x7_t2", 0, 0, 0, 0, 0, 0, 1, 7, 2, 32'h11, 0);
        rd("rd_x7", 0, 7);
        chk("x7.data", 64'(bus.rdData[63:32]), 64'h11);
        chk("x7.rdy", 64'(bus.rdReady[1]), 64'h0);
        chk("x7.tag", 64'(bus.rdTag[5:3]), 64'h4);

        // Same-cycle rename and commit of x9 (already busy with tag 1).
        step("ren_x9", 0, 0, 0, 1, 9, 1, 0, 0, 0, '0, 0);
        step("ren_cmt_x9", 0, 0, 0, 1, 9, 1, 1, 9, 1, 32'h55, 0);
        rd("rd_x9", 9, 9);
        chk("x9.data", 64'(bus.rdData[31:0]), 64'h55);
        chk("x9.rdy", 64'(bus.rdReady[0]), 64'h0);
        chk("x9.tag", 64'(bus.rdTag[2:0]), 64'h1);

        // Flush with a same-cycle rename of x6.
        step("ren_x3", 0, 0, 0, 1, 3, 5, 0, 0, 0, '0, 0);
        step("ren_x4", 0, 0, 0, 1, 4, 6, 0, 0, 0, '0, 0);
        step("flush", 1, 3, 4, 1, 6, 7, 0, 0, 0, '0, 1);
        chk("flush_rd_pre.rdy", 64'(bus.rdReady), 64'h0);
        rd("rd_x3_x4", 3, 4);
        chk("flush.rdy34", 64'(bus.rdReady), 64'h3);
        rd("rd_x6", 6, 0);
        chk("flush.rdy6", 64'(bus.rdReady[0]), 64'h1);

        // Read of x5 concurrent with a matching commit.
        step("ren_x5_t3", 0, 0, 0, 1, 5, 3, 0, 0, 0, '0, 0);
        step("rd_cmt_x5", 1, 5, 0, 0, 0, 0, 1, 5, 3, 32'hABCD, 0);
`ifdef REGFILE_COMMIT_BYPASS_EN
        chk("byp.data", 64'(bus.rdData[31:0]), 64'hABCD);
        chk("byp.rdy", 64'(bus.rdReady[0]), 64'h1);
`else
        chk("nobyp.rdy", 64'(bus.rdReady[0]), 64'h0);
        chk("nobyp.tag", 64'(bus.rdTag[2:0]), 64'h3);
        chk("nobyp.data", 64'(bus.rdData[31:0]), 64'hDEADBEEF);
`endif

        // Randomized traffic on a small register window to provoke collisions.
        for (int n = 0; n < 1500; n++) begin
            bit re, ren, cen, fl;
            int a0, a1, ridx, rtag, cidx, ctag;
            re   = ($urandom_range(3) != 0);
            a0   = $urandom_range(7);
            a1   = $urandom_range(7);
            fl   = ($urandom_range(31) == 0);
            ren  = !fl && ($urandom_range(1) == 1);
            ridx = $urandom_range(7);
            rtag = $urandom_range(7);
            cen  = ($urandom_range(1) == 1);
            cidx = $urandom_range(7);
            ctag = ($urandom_range(1) == 1) ? int'(m_tag[cidx]) : $urandom_range(7);
            step("rand", re, a0, a1, ren, ridx, rtag, cen, cidx, ctag, $urandom, fl);
        end

        // Asynchronous reset mid-operation.
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst_idle", 0, 5, 9, 0, 0, 0, 0, 0, 0, '0, 0);
        rd("post_rst_rd", 5, 9);
        chk("post_rst.rdy", 64'(bus.rdReady), 64'h3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/regfile_rob.md
# regfile_rob

Parametrised architectural register file with per-register rename status for the out-of-order core. It holds XLEN-bit architectural values and a busy bit plus ROB tag for every register. It serves NREAD source-operand lookups per cycle with registered outputs, and accepts one rename (dispatch) and one commit (ROB retire) per cycle. It sits between the decoder/dispatch stage and the ROB. It replaces the earlier edge-triggered, single-lookup register file with a clocked, multi-port, rename-aware one.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, architectural register count (index width RW = clog2(NREG))
- TAG_W, 3, ROB tag width
- NREAD, 2, number of read ports

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rdEnable  in  1  sample read addresses this cycle
- rdAddr  in  NREAD*RW  read indices, port p at [p*RW +: RW]
- rdData  out  NREAD*XLEN  register value per port
- rdTag  out  NREAD*TAG_W  producing ROB tag per port
- rdReady  out  NREAD  1 = rdData valid; 0 = wait on rdTag
- rdValid  out  1  read results valid
- renameEnable  in  1  dispatch writes destination mapping
- renameIndex  in  RW  destination register
- renameTag  in  TAG_W  ROB entry allocated to it
- commitEnable  in  1  ROB retires an entry
- commitIndex  in  RW  destination register of the retiring entry
- commitTag  in  TAG_W  tag of the retiring entry
- commitData  in  XLEN  retired value
- flush  in  1  mispredict recovery, clears all rename state

## Operation
- State: value[NREG], busy[NREG], tag[NREG].
- Reset (async, rst_n low) sets all value, busy and tag entries to 0. It also sets rdData, rdTag, rdReady and rdValid to 0.
- Register 0: reads always return data 0, tag 0, ready 1. Rename and commit to index 0 are ignored.
- Read: when rdEnable is high, each port p captures the following state at the next edge:
  - value[rdAddr_p]
  - tag[rdAddr_p]
  - ready = !busy[rdAddr_p]
- Read ordering: reads observe state before any same-cycle rename, because sources are read ahead of the destination rename.
- Read with commit: reads observe state before any same-cycle commit, unless the bypass feature applies.
- Commit: value[commitIndex] <= commitData. The write happens unconditionally (in-order retire guarantees the newest architectural value).
- Commit busy handling: busy is cleared only if busy is set and tag[commitIndex] == commitTag. A stale tag leaves busy and tag untouched.
- Rename: busy[renameIndex] <= 1 and tag[renameIndex] <= renameTag.
- Rename and commit to the same index in the same cycle: the value is written, busy stays 1 and tag takes renameTag.
- Flush:
  - Clears every busy bit. Tags and values are retained.
  - Flush overrides a same-cycle rename (no busy set).
  - A same-cycle commit still writes its value.
  - A same-cycle read captures pre-flush state.
- Multiple read ports may address the same register, and each returns identical results.

## Timing
- Read latency: 1 cycle. rdValid <= rdEnable each cycle, and outputs hold until the next rdEnable.
- Rename and commit take effect at the edge. A read issued in the following cycle sees them.
- No back-pressure: every port is accepted every cycle.
- Reset mid-operation: all outputs drop to 0 immediately. rdValid stays 0 until the first rdEnable after release.

## Configuration
- REGFILE_COMMIT_BYPASS_EN defined: a read port whose address matches commitIndex (non-zero) in the same cycle, with commitEnable high and tag[commitIndex] == commitTag while busy, captures data = commitData and ready = 1.
- REGFILE_COMMIT_BYPASS_EN undefined: no forwarding. That read captures ready = 0 with the old tag, and the consumer waits for the ROB broadcast.

## Test plan
- Reset then read x5 and x0 -> one cycle later: data 0, ready 1 on both ports, rdValid 1.
- Rename x5 to tag 3, next cycle read x5 -> ready 0, tag 3. Commit x5/tag 3/data 0xDEADBEEF, next cycle read -> data 0xDEADBEEF, ready 1.
- Rename x7 to tag 2, then rename x7 to tag 4, then commit x7/tag 2/data 0x11 -> read shows data 0x11, ready 0, tag 4.
- Same cycle: rename x9 to tag 1 and commit x9 (tag 1, data 0x55, busy tag 1) -> read shows data 0x55, ready 0, tag 1.
- Rename x3 and x4, then flush together with a rename of x6 -> x3, x4, x6 all read ready 1 with old values.
- Read x5 in the same cycle as a matching commit of 0xABCD -> with REGFILE_COMMIT_BYPASS_EN: data 0xABCD, ready 1. Without it: ready 0, tag 3.
